// File: rtl/xs3_2_bcd_seq_pkg.sv
// Shared constants and FSM state type for the XS3 to BCD decoder.
// Imported by xs3_digit_dec and xs3_2_bcd_seq.
package xs3_pkg;

  localparam logic [3:0] XS3_OFFSET  = 4'd3;
  localparam logic [3:0] XS3_MIN     = 4'd3;
  localparam logic [3:0] XS3_MAX     = 4'd12;
  localparam logic [3:0] BCD_INVALID = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/xs3_2_bcd_seq_digit_dec.sv
// Combinational single-digit XS3 to BCD decode.
// Ports: xs3 (4b code in), bcd (4b digit out, F if invalid), err (invalid code).
module xs3_digit_dec
  import xs3_pkg::*;
(
  input  logic [3:0] xs3,
  output logic [3:0] bcd,
  output logic       err
);

  always_comb begin
    err = (xs3 < XS3_MIN) || (xs3 > XS3_MAX);
    bcd = err ? BCD_INVALID : xs3 - XS3_OFFSET;
  end

endmodule

// File: rtl/xs3_2_bcd_seq.sv
// Digit-serial XS3 to BCD decoder, MSB digit first, valid/ready in and out.
// Ports: clk, rst_n (sync, active-low), in_valid/in_ready/in_xs3,
// out_valid/out_ready/out_bcd/out_err/out_err_mask, out_bin (XS3_BIN_EN only).
module xs3_2_bcd_seq
  import xs3_pkg::*;
#(
  parameter int NDIG  = 4,
  parameter int BIN_W = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*NDIG-1:0] in_xs3,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*NDIG-1:0] out_bcd,
  output logic              out_err,
  output logic [NDIG-1:0]   out_err_mask
`ifdef XS3_BIN_EN
  ,
  output logic [BIN_W-1:0]  out_bin
`endif
);

  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;

  if (NDIG < 1 || NDIG > 8 || BIN_W < 1) begin : g_bad_cfg
    $error("xs3_2_bcd_seq: illegal NDIG/BIN_W");
  end

  state_t state, state_nxt;

  logic [4*NDIG-1:0] xs3_q;
  logic [CW-1:0]     cnt;
  logic [3:0]        dig_xs3;
  logic [3:0]        dig_bcd;
  logic              dig_err;

  // Counter-indexed digit mux feeding the single decoder.
  always_comb begin
    dig_xs3 = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (cnt == CW'(i)) dig_xs3 = xs3_q[4*i +: 4];
    end
  end

  xs3_digit_dec u_dec (
    .xs3 (dig_xs3),
    .bcd (dig_bcd),
    .err (dig_err)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = CONV;
      end
      CONV: begin
        if (cnt == '0) state_nxt = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      xs3_q        <= '0;
      cnt          <= '0;
      out_bcd      <= '0;
      out_err_mask <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            xs3_q        <= in_xs3;
            cnt          <= CW'(NDIG - 1);
            out_bcd      <= '0;
            out_err_mask <= '0;
          end
        end
        CONV: begin
          for (int i = 0; i < NDIG; i++) begin
            if (cnt == CW'(i)) begin
              out_bcd[4*i +: 4] <= dig_bcd;
              out_err_mask[i]   <= dig_err;
            end
          end
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out_err = |out_err_mask;

`ifdef XS3_BIN_EN
  // Horner accumulation, MSB digit first; invalid digits add zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_bin <= '0;
    end else if (state == IDLE && in_valid) begin
      out_bin <= '0;
    end else if (state == CONV) begin
      out_bin <= out_bin * BIN_W'(10)
               + BIN_W'(dig_err ? 4'd0 : dig_bcd);
    end
  end
`endif

endmodule
